// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: active-low 7-segment font
// ({dp,g,f,e,d,c,b,a}), the all-dark pattern and the decimal-point mask.
package fnd_pkg;

  localparam logic [7:0] FND_FONT [16] = '{
    8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e
  };

  localparam logic [7:0] FND_OFF     = 8'hff;
  localparam logic [7:0] FND_DP_MASK = 8'h7f;

endpackage

// File: rtl/fnd_font.sv
// Combinational hex nibble to active-low 7-segment font lookup.
module fnd_font
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] font
);

  assign font = FND_FONT[nibble];

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed common-anode 7-segment driver.
// Inputs are latched into shadow registers once per frame; every slot starts
// with DEAD dark cycles to suppress ghosting. All outputs are registered.
// Optional macro FND_LZB_EN enables leading-zero blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEAD     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  output logic [DIGITS-1:0]     o_fndCom,
  output logic [7:0]            o_fndFont,
  output logic                  o_frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]            cnt;
  logic [DW-1:0]            dig;
  logic [DIGITS-1:0][3:0]   shValue;
  logic [DIGITS-1:0]        shDp;
  logic [DIGITS-1:0]        shBlank;
  logic [DIGITS-1:0]        lzb;
  logic [DIGITS-1:0]        comSel;
  logic                     frameStart;
  logic                     cntWrap;
  logic                     inDead;
  logic [3:0]               curNib;
  logic                     curDp;
  logic                     curBlank;
  logic                     curLit;
  logic [7:0]               fontRaw;
  logic [7:0]               segNext;

  assign frameStart = (cnt == '0) && (dig == '0);
  assign cntWrap    = (cnt == CW'(SCAN_DIV - 1));
  assign inDead     = (cnt < CW'(DEAD));

  // Slot counter and digit index; dig steps once per slot wrap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
      dig <= '0;
    end else if (cntWrap) begin
      cnt <= '0;
      dig <= (dig == DW'(DIGITS - 1)) ? '0 : dig + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers load only at frame start so a frame is never torn.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shValue <= '0;
      shDp    <= '0;
      shBlank <= '0;
    end else if (frameStart) begin
      shValue <= i_value;
      shDp    <= i_dp;
      shBlank <= i_blank;
    end
  end

`ifdef FND_LZB_EN
  logic lzRun;
  // Leading-zero blanking: scan down from the top digit while nibbles are zero;
  // digit 0 is always shown.
  always_comb begin
    lzb   = '0;
    lzRun = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lzRun  = lzRun && (shValue[k] == 4'h0);
      lzb[k] = lzRun;
    end
  end
`else
  assign lzb = '0;
`endif

  // Select the shadow data for the current digit.
  always_comb begin
    curNib   = shValue[dig];
    curDp    = shDp[dig];
    curBlank = shBlank[dig] | lzb[dig];
    comSel   = '1;
    comSel[dig] = 1'b0;
  end

  fnd_font uFont (
    .nibble (curNib),
    .font   (fontRaw)
  );

  // Apply blank and decimal point; an entirely dark digit keeps its common off.
  always_comb begin
    segNext = curBlank ? FND_OFF : fontRaw;
    if (curDp) segNext = segNext & FND_DP_MASK;
    curLit  = !curBlank || curDp;
  end

  // Registered pin drivers: dark during dead-time, disable or unlit digit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fndCom  <= '1;
      o_fndFont <= FND_OFF;
      o_frame   <= 1'b0;
    end else begin
      o_frame <= frameStart;
      if (i_enable && !inDead && curLit) begin
        o_fndCom  <= comSel;
        o_fndFont <= segNext;
      end else begin
        o_fndCom  <= '1;
        o_fndFont <= FND_OFF;
      end
    end
  end

endmodule
